// File: rtl/alu_pkg.sv
// Shared execute-stage ALU definitions: operation encodings and M-extension decode helpers.
// Imported by the ALU, the multi-cycle mul/div unit and their interfaces.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_t;

  // sel_hi picks the upper product half for multiplies and the remainder for divides.
  typedef struct packed {
    logic is_div;
    logic a_signed;
    logic b_signed;
    logic sel_hi;
  } muldiv_ctl_t;

  function automatic logic is_muldiv(alu_op_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic muldiv_ctl_t decode_muldiv(alu_op_t op);
    muldiv_ctl_t ctl;
    ctl = '0;
    case (op)
      ALU_MULH:   ctl = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b1, sel_hi: 1'b1};
      ALU_MULHSU: ctl = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b0, sel_hi: 1'b1};
      ALU_MULHU:  ctl = '{is_div: 1'b0, a_signed: 1'b0, b_signed: 1'b0, sel_hi: 1'b1};
      ALU_DIV:    ctl = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, sel_hi: 1'b0};
      ALU_DIVU:   ctl = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, sel_hi: 1'b0};
      ALU_REM:    ctl = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, sel_hi: 1'b1};
      ALU_REMU:   ctl = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, sel_hi: 1'b1};
      default:    ctl = '0;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bus between the execute stage and the multi-cycle mul/div unit.
// The core drives the master side; muldiv_unit sits on the slave side.
interface muldiv_unit_if #(
    parameter int N = 64
);
    logic              kill;
    logic              req_valid;
    logic              req_ready;
    alu_pkg::alu_op_t  alu_op;
    logic [N-1:0]      A;
    logic [N-1:0]      B;
    logic              resp_valid;
    logic              resp_ready;
    logic [N-1:0]      Y;
    logic              busy;

    modport master (
        output kill, req_valid, alu_op, A, B, resp_ready,
        input  req_ready, resp_valid, Y, busy
    );

    modport slave (
        input  kill, req_valid, alu_op, A, B, resp_ready,
        output req_ready, resp_valid, Y, busy
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiplier / restoring divider on unsigned magnitudes,
// with the sign fix-up and half/remainder selection folded into the final step.
module muldiv_datapath
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        init,
    input  logic        step,
    input  muldiv_ctl_t ctl,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result
);

    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   opnd_q;
    logic           is_div_q, sel_hi_q, neg_main_q, neg_rem_q;

    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N-1:0]   hi, lo;
    logic [N:0]     sum, sh;
    logic           ge;
    logic [N-1:0]   diff;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem;

    assign a_neg = ctl.a_signed & a[N-1];
    assign b_neg = ctl.b_signed & b[N-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign hi = acc_q[2*N-1:N];
    assign lo = acc_q[N-1:0];

    // Multiply: {hi,lo} starts as {0, multiplier}. Divide: {rem, quotient} starts as {0, dividend}.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
        sh    = {hi, lo[N-1]};
        ge    = sh >= {1'b0, opnd_q};
        diff  = sh[N-1:0] - opnd_q;
        acc_d = {sum, lo[N-1:1]};
        if (is_div_q) begin
            acc_d = {(ge ? diff : sh[N-1:0]), lo[N-2:0], ge};
        end
    end

    always_comb begin
        prod   = neg_main_q ? -acc_d : acc_d;
        quo    = neg_main_q ? -acc_d[N-1:0] : acc_d[N-1:0];
        rem    = neg_rem_q ? -acc_d[2*N-1:N] : acc_d[2*N-1:N];
        result = sel_hi_q ? prod[2*N-1:N] : prod[N-1:0];
        if (is_div_q) begin
            result = sel_hi_q ? rem : quo;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: these are plain flops rather than a RAM, so they take the reset and X never reaches Y.
        if (!reset_n) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            sel_hi_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (init) begin
            acc_q      <= {{N{1'b0}}, (ctl.is_div ? a_mag : b_mag)};
            opnd_q     <= ctl.is_div ? b_mag : a_mag;
            is_div_q   <= ctl.is_div;
            sel_hi_q   <= ctl.sel_hi;
            neg_main_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
        end else if (step) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit: handshake FSM, special-case shortcuts and result register
// around muldiv_datapath, which iterates one bit per clock.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic clock,
    input  logic reset_n,
    muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {Idle, Calc, Done} muldiv_state_t;

    muldiv_state_t state_q, state_d;
    logic [CW-1:0] count_q;
    logic [N-1:0]  y_q, dp_result, special_y;
    logic          accept, special, last;
    muldiv_ctl_t   ctl;

    assign ctl    = decode_muldiv(bus.alu_op);
    assign accept = bus.req_valid && (state_q == Idle) && !bus.kill;
    assign last   = (state_q == Calc) && (count_q == '0);

    // Division by zero, signed overflow and non-M ops are answered without iterating.
    always_comb begin
        special   = 1'b0;
        special_y = '0;
        if (!is_muldiv(bus.alu_op)) begin
            special = 1'b1;
        end else if (ctl.is_div && bus.B == '0) begin
            special   = 1'b1;
            special_y = ctl.sel_hi ? bus.A : '1;
        end else if (ctl.is_div && ctl.a_signed && ctl.b_signed &&
                     bus.A == INT_MIN && bus.B == '1) begin
            special   = 1'b1;
            special_y = ctl.sel_hi ? '0 : bus.A;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            Idle:    if (accept) state_d = special ? Done : Calc;
            Calc:    if (count_q == '0) state_d = Done;
            Done:    if (bus.resp_ready) state_d = Idle;
            default: state_d = Idle;
        endcase
        if (bus.kill) state_d = Idle;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (!reset_n) state_q <= Idle;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= CW'(N - 1);
        end else if (state_q == Calc && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    // A killed op never overwrites Y; the last valid result simply stays put.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            y_q <= '0;
        end else if (accept && special) begin
            y_q <= special_y;
        end else if (last && !bus.kill) begin
            y_q <= dp_result;
        end
    end

    muldiv_datapath #(.N(N)) u_datapath (
        .clock   (clock),
        .reset_n (reset_n),
        .init    (accept),
        .step    (state_q == Calc),
        .ctl     (ctl),
        .a       (bus.A),
        .b       (bus.B),
        .result  (dp_result)
    );

    assign bus.req_ready  = (state_q == Idle);
    assign bus.resp_valid = (state_q == Done);
    assign bus.busy       = (state_q != Idle);
    assign bus.Y          = y_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at N=8 and N=64: directed corner cases, handshake,
// kill/reset behaviour, then random ops against a wide-integer arithmetic reference.
module tb_muldiv_unit;
    import alu_pkg::*;

    logic clock;
    logic reset_n;

    muldiv_unit_if #(.N(8))  bus8 ();
    muldiv_unit_if #(.N(64)) bus64 ();

    muldiv_unit #(.N(8))  dut8  (.clock(clock), .reset_n(reset_n), .bus(bus8));
    muldiv_unit #(.N(64)) dut64 (.clock(clock), .reset_n(reset_n), .bus(bus64));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    typedef struct {
        alu_op_t    op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        int         lat;
    } vec_t;

    vec_t vecs [10] = '{
        '{ALU_MULH,   8'h80, 8'h80, 8'h40, 9},
        '{ALU_MUL,    8'h80, 8'h80, 8'h00, 9},
        '{ALU_DIV,    8'hF9, 8'h02, 8'hFD, 9},
        '{ALU_REM,    8'hF9, 8'h02, 8'hFF, 9},
        '{ALU_MULHSU, 8'hFF, 8'hFF, 8'hFF, 9},
        '{ALU_DIVU,   8'h2A, 8'h00, 8'hFF, 1},
        '{ALU_REMU,   8'h2A, 8'h00, 8'h2A, 1},
        '{ALU_DIV,    8'h80, 8'hFF, 8'h80, 1},
        '{ALU_REM,    8'h80, 8'hFF, 8'h00, 1},
        '{ALU_ADD,    8'h05, 8'h03, 8'h00, 1}
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: operands as exact integers, results reduced to n bits.
    function automatic logic [63:0] ref_model(alu_op_t op, logic [63:0] a, logic [63:0] b, int n);
        logic [63:0]         mask;
        logic signed [129:0] ua, ub, sa, sb, two_n, r;
        mask  = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        two_n = 130'sd1 <<< n;
        ua    = $signed({66'd0, a & mask});
        ub    = $signed({66'd0, b & mask});
        sa    = a[n-1] ? ua - two_n : ua;
        sb    = b[n-1] ? ub - two_n : ub;
        case (op)
            ALU_MUL:    r = ua * ub;
            ALU_MULH:   r = (sa * sb) >>> n;
            ALU_MULHSU: r = (sa * ub) >>> n;
            ALU_MULHU:  r = (ua * ub) >>> n;
            ALU_DIV:    r = (ub == 0) ? -130'sd1 : sa / sb;
            ALU_DIVU:   r = (ub == 0) ? -130'sd1 : ua / ub;
            ALU_REM:    r = (ub == 0) ? ua : sa % sb;
            ALU_REMU:   r = (ub == 0) ? ua : ua % ub;
            default:    r = '0;
        endcase
        return r[63:0] & mask;
    endfunction

    function automatic int exp_latency(alu_op_t op, logic [63:0] a, logic [63:0] b, int n);
        logic [63:0] mask, int_min;
        logic        is_m, is_d, ovf;
        mask    = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        int_min = 64'd1 << (n - 1);
        is_m    = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                             ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        is_d    = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        ovf     = (op == ALU_DIV || op == ALU_REM) && a == int_min && b == mask;
        if (!is_m || (is_d && b == '0) || ovf) return 1;
        return n + 1;
    endfunction

    function automatic logic [63:0] rnd_operand(int n);
        logic [63:0] mask, v;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        case ($urandom_range(0, 9))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'd1 << (n - 1);
            3:       v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    task automatic drive_req(input bit w64, input logic v, input alu_op_t op,
                             input logic [63:0] a, input logic [63:0] b);
        if (w64) begin
            bus64.req_valid = v; bus64.alu_op = op; bus64.A = a; bus64.B = b;
        end else begin
            bus8.req_valid = v; bus8.alu_op = op; bus8.A = a[7:0]; bus8.B = b[7:0];
        end
    endtask

    task automatic set_resp_ready(input bit w64, input logic v);
        if (w64) bus64.resp_ready = v;
        else     bus8.resp_ready  = v;
    endtask

    function automatic logic [63:0] get_y(bit w64);
        return w64 ? bus64.Y : {56'd0, bus8.Y};
    endfunction

    function automatic logic get_rv(bit w64);
        return w64 ? bus64.resp_valid : bus8.resp_valid;
    endfunction

    function automatic logic get_rr(bit w64);
        return w64 ? bus64.req_ready : bus8.req_ready;
    endfunction

    function automatic logic get_busy(bit w64);
        return w64 ? bus64.busy : bus8.busy;
    endfunction

    // Issue one request, scramble the inputs after accept, and wait (bounded) for resp_valid.
    // lat counts edges from accept to the first edge that samples resp_valid high.
    task automatic issue(input bit w64, input alu_op_t op, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] y, output int lat);
        int cyc;
        drive_req(w64, 1'b1, op, a, b);
        @(posedge clock); #1;
        drive_req(w64, 1'b0, alu_op_t'(5'($urandom_range(0, 17))),
                  {$urandom, $urandom}, {$urandom, $urandom});
        cyc = 0;
        while (!get_rv(w64) && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        lat = cyc + 1;
        y   = get_y(w64);
    endtask

    task automatic release_resp(input bit w64);
        set_resp_ready(w64, 1'b1);
        @(posedge clock); #1;
        set_resp_ready(w64, 1'b0);
    endtask

    initial begin
        logic [63:0] y, a, b;
        int          lat, n;
        bit          w64, seen;
        alu_op_t     op;

        bus8.kill = 1'b0;  bus8.resp_ready = 1'b0;
        bus64.kill = 1'b0; bus64.resp_ready = 1'b0;
        drive_req(1'b0, 1'b0, ALU_ADD, '0, '0);
        drive_req(1'b1, 1'b0, ALU_ADD, '0, '0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int w = 0; w < 2; w++) begin
            check($sformatf("reset%0d_req_ready", w), 64'(get_rr(w == 1)), 64'd1);
            check($sformatf("reset%0d_resp_valid", w), 64'(get_rv(w == 1)), 64'd0);
            check($sformatf("reset%0d_busy", w), 64'(get_busy(w == 1)), 64'd0);
            check($sformatf("reset%0d_y", w), get_y(w == 1), 64'd0);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            issue(1'b0, vecs[i].op, {56'd0, vecs[i].a}, {56'd0, vecs[i].b}, y, lat);
            check($sformatf("dir_%s_%h_%h_y", vecs[i].op.name(), vecs[i].a, vecs[i].b),
                  y, {56'd0, vecs[i].y});
            check($sformatf("dir_%s_%h_%h_lat", vecs[i].op.name(), vecs[i].a, vecs[i].b),
                  64'(lat), 64'(vecs[i].lat));
            release_resp(1'b0);
        end

        // Backpressure: hold resp_ready low for three cycles in Done.
        issue(1'b0, ALU_DIV, 64'hF9, 64'h02, y, lat);
        check("bp_first_y", y, 64'hFD);
        repeat (3) begin
            @(posedge clock); #1;
            check("bp_hold_y", get_y(1'b0), 64'hFD);
            check("bp_hold_resp_valid", 64'(get_rv(1'b0)), 64'd1);
            check("bp_hold_req_ready", 64'(get_rr(1'b0)), 64'd0);
        end
        release_resp(1'b0);
        check("bp_release_resp_valid", 64'(get_rv(1'b0)), 64'd0);
        check("bp_release_req_ready", 64'(get_rr(1'b0)), 64'd1);

        // Kill during the fourth Calc cycle.
        drive_req(1'b0, 1'b1, ALU_MUL, 64'h12, 64'h34);
        @(posedge clock); #1;
        drive_req(1'b0, 1'b0, ALU_MUL, '0, '0);
        check("kill_busy_before", 64'(get_busy(1'b0)), 64'd1);
        repeat (3) begin @(posedge clock); #1; end
        bus8.kill = 1'b1;
        @(posedge clock); #1;
        bus8.kill = 1'b0;
        check("kill_busy_after", 64'(get_busy(1'b0)), 64'd0);
        check("kill_req_ready_after", 64'(get_rr(1'b0)), 64'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clock); #1;
            if (get_rv(1'b0)) seen = 1'b1;
        end
        check("kill_no_resp_valid", 64'(seen), 64'd0);

        // Kill in Idle blocks acceptance.
        bus8.kill = 1'b1;
        drive_req(1'b0, 1'b1, ALU_DIVU, 64'h40, 64'h03);
        @(posedge clock); #1;
        drive_req(1'b0, 1'b0, ALU_ADD, '0, '0);
        bus8.kill = 1'b0;
        check("kill_idle_not_accepted", 64'(get_busy(1'b0)), 64'd0);

        // Reset mid-Calc: outputs return to reset values without waiting for a clock edge.
        drive_req(1'b0, 1'b1, ALU_MULHU, 64'hC3, 64'h5A);
        @(posedge clock); #1;
        drive_req(1'b0, 1'b0, ALU_ADD, '0, '0);
        repeat (3) begin @(posedge clock); #1; end
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(get_busy(1'b0)), 64'd0);
        check("rst_mid_req_ready", 64'(get_rr(1'b0)), 64'd1);
        check("rst_mid_resp_valid", 64'(get_rv(1'b0)), 64'd0);
        check("rst_mid_y", get_y(1'b0), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clock); #1;
            if (get_rv(1'b0)) seen = 1'b1;
        end
        check("rst_mid_no_resp_valid", 64'(seen), 64'd0);

        // Random ops against the reference model, stopping at the first discrepancy.
        for (int w = 0; w < 2; w++) begin
            w64 = (w == 1);
            n   = w64 ? 64 : 8;
            for (int i = 0; i < 1000; i++) begin
                op = alu_op_t'(5'($urandom_range(0, 17)));
                a  = rnd_operand(n);
                b  = rnd_operand(n);
                issue(w64, op, a, b, y, lat);
                check($sformatf("rand%0d_%s_%h_%h_y", n, op.name(), a, b), y, ref_model(op, a, b, n));
                check($sformatf("rand%0d_%s_%h_%h_lat", n, op.name(), a, b),
                      64'(lat), 64'(exp_latency(op, a, b, n)));
                release_resp(w64);
                if (n_fail != 0) begin
                    $display("%0d/%0d checks passed", n_pass, n_checks);
                    $fatal(1, "stopping at first random-op discrepancy");
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
